// File: rtl/lock_input_conditioner.sv
// lock_input_conditioner
//   Front-end for the password-lock FSM. Synchronises the two raw buttons and
//   the code switches, debounces the buttons and emits one-cycle pulses on
//   accepted releases. Each pulse comes with a stable code snapshot.
//   A holdoff window after every pulse drops later releases.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   btn_set_raw    raw set-password button (async)
//   btn_enter_raw  raw enter button (async)
//   code_raw[6:0]  raw code switches (async)
//   set_pulse      1-cycle pulse on accepted set release
//   enter_pulse    1-cycle pulse on accepted enter release
//   code_out[6:0]  code captured with the most recent pulse
//   set_level      debounced set level
//   enter_level    debounced enter level
//   collision      1-cycle flag: both releases accepted together

// lock_debounce
//   Debounces one synchronised button. The level changes only after the
//   input has held the new value for DEBOUNCE_CYCLES consecutive samples.
//   release_evt is combinational and is high during the cycle whose edge
//   moves the FSM from PEND_LOW to LOW; the parent registers it.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   LOW       | stable released, level=0
//   PEND_HIGH | input high, counting towards accepting a press
//   HIGH      | stable pressed, level=1
//   PEND_LOW  | input low, counting towards accepting a release
module lock_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic level,
  output logic release_evt
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_PEND_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_PEND_LOW  = 2'd3
  } state_t;

  // With a debounce of one cycle the first differing sample is accepted
  // directly, skipping the pending state.
  localparam bit          FAST = (DEBOUNCE_CYCLES <= 16'd1);
  localparam logic [15:0] LAST = FAST ? 16'd0 : DEBOUNCE_CYCLES - 16'd1;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        done;
  logic [15:0] cnt_inc;

  assign done    = (cnt_q >= LAST);
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    release_evt = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync_in) begin
          if (FAST) begin
            state_d = S_HIGH;
            level_d = 1'b1;
            cnt_d   = 16'd0;
          end else begin
            state_d = S_PEND_HIGH;
            cnt_d   = 16'd1;
          end
        end
      end
      S_PEND_HIGH: begin
        if (!sync_in) begin
          state_d = S_LOW;
          cnt_d   = 16'd0;
        end else if (done) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HIGH: begin
        if (!sync_in) begin
          if (FAST) begin
            state_d     = S_LOW;
            level_d     = 1'b0;
            cnt_d       = 16'd0;
            release_evt = 1'b1;
          end else begin
            state_d = S_PEND_LOW;
            cnt_d   = 16'd1;
          end
        end
      end
      S_PEND_LOW: begin
        if (sync_in) begin
          state_d = S_HIGH;
          cnt_d   = 16'd0;
        end else if (done) begin
          state_d     = S_LOW;
          level_d     = 1'b0;
          cnt_d       = 16'd0;
          release_evt = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = 16'd0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= 16'd0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

module lock_input_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
  parameter logic [15:0] HOLDOFF_CYCLES  = 16'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_set_raw,
  input  logic       btn_enter_raw,
  input  logic [6:0] code_raw,
  output logic       set_pulse,
  output logic       enter_pulse,
  output logic [6:0] code_out,
  output logic       set_level,
  output logic       enter_level,
  output logic       collision
);

  logic       set_s1_q, set_s2_q;
  logic       enter_s1_q, enter_s2_q;
  logic [6:0] code_s1_q, code_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      set_s1_q   <= 1'b0;
      set_s2_q   <= 1'b0;
      enter_s1_q <= 1'b0;
      enter_s2_q <= 1'b0;
      code_s1_q  <= 7'd0;
      code_s2_q  <= 7'd0;
    end else begin
      set_s1_q   <= btn_set_raw;
      set_s2_q   <= set_s1_q;
      enter_s1_q <= btn_enter_raw;
      enter_s2_q <= enter_s1_q;
      code_s1_q  <= code_raw;
      code_s2_q  <= code_s1_q;
    end
  end

  logic set_rel, enter_rel;

  lock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
    .clk         (clk),
    .rst         (rst),
    .sync_in     (set_s2_q),
    .level       (set_level),
    .release_evt (set_rel)
  );

  lock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
    .clk         (clk),
    .rst         (rst),
    .sync_in     (enter_s2_q),
    .level       (enter_level),
    .release_evt (enter_rel)
  );

  logic        set_pulse_q, set_pulse_d;
  logic        enter_pulse_q, enter_pulse_d;
  logic        collision_q, collision_d;
  logic [6:0]  code_q, code_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_free;
  logic        emit;

  always_comb begin
    hold_free     = (hold_q == 16'd0);
    // Enter has priority; a simultaneous set release is folded into the
    // same pulse and only flagged via collision.
    enter_pulse_d = enter_rel & hold_free;
    set_pulse_d   = set_rel & ~enter_rel & hold_free;
    collision_d   = set_rel & enter_rel & hold_free;
    emit          = enter_pulse_d | set_pulse_d;
    code_d        = emit ? code_s2_q : code_q;
    if (emit) begin
      hold_d = HOLDOFF_CYCLES;
    end else if (!hold_free) begin
      hold_d = hold_q - 16'd1;
    end else begin
      hold_d = hold_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_pulse_q   <= 1'b0;
      enter_pulse_q <= 1'b0;
      collision_q   <= 1'b0;
      code_q        <= 7'd0;
      hold_q        <= 16'd0;
    end else begin
      set_pulse_q   <= set_pulse_d;
      enter_pulse_q <= enter_pulse_d;
      collision_q   <= collision_d;
      code_q        <= code_d;
      hold_q        <= hold_d;
    end
  end

  assign set_pulse   = set_pulse_q;
  assign enter_pulse = enter_pulse_q;
  assign collision   = collision_q;
  assign code_out    = code_q;

endmodule

// File: tb/tb_lock_input_conditioner.sv
// tb_lock_input_conditioner
//   Directed scenarios followed by a random phase. A cycle-level reference
//   model built on run lengths (consecutive samples disagreeing with the
//   accepted level) predicts every output each cycle.
module tb_lock_input_conditioner;

  localparam int DEB  = 1000;
  localparam int HOLD = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_set_raw = 1'b0;
  logic       btn_enter_raw = 1'b0;
  logic [6:0] code_raw = 7'd0;
  logic       set_pulse, enter_pulse, set_level, enter_level, collision;
  logic [6:0] code_out;

  lock_input_conditioner #(
    .DEBOUNCE_CYCLES(16'(DEB)),
    .HOLDOFF_CYCLES (16'(HOLD))
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_set_raw   (btn_set_raw),
    .btn_enter_raw (btn_enter_raw),
    .code_raw      (code_raw),
    .set_pulse     (set_pulse),
    .enter_pulse   (enter_pulse),
    .code_out      (code_out),
    .set_level     (set_level),
    .enter_level   (enter_level),
    .collision     (collision)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_set_seen = 0;
  int n_ent_seen = 0;
  bit saw_set_level = 1'b0;

  // reference model state
  logic       m_s1_set = 0, m_s2_set = 0, m_s1_ent = 0, m_s2_ent = 0;
  logic [6:0] m_c1 = 0, m_c2 = 0;
  logic       m_lvl_set = 0, m_lvl_ent = 0;
  int         m_run_set = 0, m_run_ent = 0;
  int         m_hold = 0;
  logic       m_set_p = 0, m_ent_p = 0, m_col = 0;
  logic [6:0] m_code = 0;

  // A level flips once the sampled input has disagreed with it for DEB
  // samples in a row; a falling flip is a release.
  function automatic void deb_step(input logic smp, inout logic lvl,
                                   inout int run, output logic rel);
    rel = 1'b0;
    if (smp != lvl) begin
      run++;
      if (run >= DEB) begin
        lvl = smp;
        run = 0;
        rel = ~smp;
      end
    end else begin
      run = 0;
    end
  endfunction

  task automatic model_step();
    logic rs, re;
    if (rst) begin
      m_s1_set = 0; m_s2_set = 0; m_s1_ent = 0; m_s2_ent = 0;
      m_c1 = 0; m_c2 = 0;
      m_lvl_set = 0; m_lvl_ent = 0; m_run_set = 0; m_run_ent = 0;
      m_hold = 0; m_set_p = 0; m_ent_p = 0; m_col = 0; m_code = 0;
    end else begin
      deb_step(m_s2_set, m_lvl_set, m_run_set, rs);
      deb_step(m_s2_ent, m_lvl_ent, m_run_ent, re);
      if (m_hold == 0 && (rs || re)) begin
        m_ent_p = re;
        m_set_p = rs && !re;
        m_col   = rs && re;
        m_code  = m_c2;
        m_hold  = HOLD;
      end else begin
        m_ent_p = 0; m_set_p = 0; m_col = 0;
        if (m_hold > 0) m_hold--;
      end
      m_s2_set = m_s1_set; m_s1_set = btn_set_raw;
      m_s2_ent = m_s1_ent; m_s1_ent = btn_enter_raw;
      m_c2 = m_c1; m_c1 = code_raw;
    end
  endtask

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  endtask

  task automatic tick();
    logic [11:0] obs, exp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    obs = {set_pulse, enter_pulse, collision, set_level, enter_level, code_out};
    exp = {m_set_p, m_ent_p, m_col, m_lvl_set, m_lvl_ent, m_code};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL model_cycle %0d obs=%h exp=%h (set_p,ent_p,col,set_lvl,ent_lvl,code)",
             cyc, obs, exp);
    end
    if (set_pulse === 1'b1) n_set_seen++;
    if (enter_pulse === 1'b1) n_ent_seen++;
    if (set_level === 1'b1) saw_set_level = 1'b1;
    if (n_fail > 100) summary_and_finish();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until enter_pulse is seen; returns the number of ticks taken,
  // or maxc if it never appeared.
  task automatic wait_enter(input int maxc, output int c);
    c = 0;
    while (enter_pulse !== 1'b1 && c < maxc) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_set(input int maxc, output int c);
    c = 0;
    while (set_pulse !== 1'b1 && c < maxc) begin
      tick();
      c++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    // reset
    rst = 1'b1;
    ticks(3);
    chk("reset_outputs", {set_pulse, enter_pulse, collision, set_level, enter_level, code_out}, 32'd0);
    rst = 1'b0;
    ticks(2);

    // 1: clean enter press/release
    code_raw = 7'h35;
    btn_enter_raw = 1'b1;
    ticks(2000);
    chk("t1_level_high", enter_level, 1);
    btn_enter_raw = 1'b0;
    wait_enter(1100, c);
    chk("t1_latency", c, DEB + 2);
    chk("t1_code", code_out, 7'h35);
    chk("t1_level_low", enter_level, 0);
    tick();
    chk("t1_width", enter_pulse, 0);
    ticks(200);

    // 2: short set press
    n_set_seen = 0; saw_set_level = 1'b0;
    btn_set_raw = 1'b1;
    ticks(500);
    btn_set_raw = 1'b0;
    ticks(1200);
    chk("t2_no_level", saw_set_level, 0);
    chk("t2_no_pulse", n_set_seen, 0);
    chk("t2_code_held", code_out, 7'h35);

    // 3: bouncy press and release
    n_ent_seen = 0;
    for (int i = 0; i < 30; i++) begin
      btn_enter_raw = ~i[0];
      ticks(10);
    end
    btn_enter_raw = 1'b1;
    ticks(1500);
    for (int i = 0; i < 10; i++) begin
      btn_enter_raw = i[0];
      ticks(10);
    end
    btn_enter_raw = 1'b0;
    wait_enter(1100, c);
    chk("t3_latency", c, DEB + 2);
    ticks(300);
    chk("t3_one_pulse", n_ent_seen, 1);

    // 4: simultaneous release
    code_raw = 7'h12;
    btn_set_raw = 1'b1; btn_enter_raw = 1'b1;
    ticks(1500);
    btn_set_raw = 1'b0; btn_enter_raw = 1'b0;
    wait_enter(1100, c);
    chk("t4_latency", c, DEB + 2);
    chk("t4_set_suppressed", set_pulse, 0);
    chk("t4_collision", collision, 1);
    chk("t4_code", code_out, 7'h12);
    ticks(300);

    // 5a: enter release inside holdoff is dropped
    n_set_seen = 0; n_ent_seen = 0;
    code_raw = 7'h4A;
    btn_set_raw = 1'b1; btn_enter_raw = 1'b1;
    ticks(1500);
    btn_set_raw = 1'b0;
    ticks(50);
    btn_enter_raw = 1'b0;
    wait_set(1000, c);
    chk("t5a_set_latency", c + 50, DEB + 2);
    chk("t5a_code", code_out, 7'h4A);
    code_raw = 7'h07;
    ticks(300);
    chk("t5a_enter_dropped", n_ent_seen, 0);
    chk("t5a_code_held", code_out, 7'h4A);
    chk("t5a_enter_level", enter_level, 0);

    // 5b: enter release after holdoff is emitted
    n_set_seen = 0; n_ent_seen = 0;
    code_raw = 7'h4A;
    btn_set_raw = 1'b1; btn_enter_raw = 1'b1;
    ticks(1500);
    btn_set_raw = 1'b0;
    ticks(150);
    btn_enter_raw = 1'b0;
    wait_set(1000, c);
    chk("t5b_set_latency", c + 150, DEB + 2);
    code_raw = 7'h07;
    wait_enter(200, c);
    chk("t5b_enter_gap", c, 150);
    chk("t5b_code", code_out, 7'h07);
    ticks(200);
    chk("t5b_pulse_count", n_set_seen + n_ent_seen, 2);

    // 6: reset mid pending release
    n_ent_seen = 0;
    btn_enter_raw = 1'b1;
    ticks(1500);
    btn_enter_raw = 1'b0;
    ticks(802);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_reset_outputs", {set_pulse, enter_pulse, collision, set_level, enter_level, code_out}, 32'd0);
    ticks(1200);
    chk("t6_no_pulse", n_ent_seen, 0);
    code_raw = 7'h5C;
    btn_enter_raw = 1'b1;
    ticks(1500);
    btn_enter_raw = 1'b0;
    wait_enter(1100, c);
    chk("t6_fresh_latency", c, DEB + 2);
    chk("t6_fresh_code", code_out, 7'h5C);
    ticks(200);

    // random phase
    for (int s = 0; s < 16; s++) begin
      btn_set_raw   = 1'($urandom_range(0, 1));
      btn_enter_raw = 1'($urandom_range(0, 1));
      code_raw      = 7'($urandom);
      rst           = ($urandom_range(0, 15) == 0);
      tick();
      rst = 1'b0;
      ticks($urandom_range(1, 1300));
    end
    btn_set_raw = 1'b0; btn_enter_raw = 1'b0;
    ticks(1300);
    chk("final_levels_low", {set_level, enter_level}, 0);

    summary_and_finish();
  end

endmodule

// File: doc/lock_input_conditioner.md
Name: lock_input_conditioner

Overview:
- Upstream front-end for the password-lock state machine.
- Takes the two raw push-buttons (set-password, enter) and the 7-bit code switches from the pads.
- Synchronises and debounces the buttons, and emits one-cycle release pulses, matching the lock FSM's act-on-release convention.
- Each pulse comes with a code snapshot that stays stable, so the lock FSM runs in the single clk domain instead of on raw pin edges.

Parameters:
DEBOUNCE_CYCLES, 16'd1000, consecutive cycles a synchronised button must hold a new level before it is accepted (min 1).
HOLDOFF_CYCLES, 16'd100, cycles after any emitted pulse during which new pulses are suppressed (0 = no holdoff).

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
btn_set_raw  input  1  raw set-password button, active-high, asynchronous to clk
btn_enter_raw  input  1  raw enter button, active-high, asynchronous to clk
code_raw  input  7  raw code switches, asynchronous to clk
set_pulse  output  1  one-cycle pulse on accepted set-button release
enter_pulse  output  1  one-cycle pulse on accepted enter-button release
code_out  output  7  code captured with the most recent pulse
set_level  output  1  debounced set-button level
enter_level  output  1  debounced enter-button level
collision  output  1  one-cycle flag: both releases accepted in the same cycle

Behaviour:
- Reset:
  - All synchroniser flops, debounced levels, counters and outputs are 0.
  - Both debounce FSMs start in LOW.
  - Holdoff counter is 0 (not active).
  - rst asserted mid-debounce or mid-holdoff aborts the operation. No pulse is emitted in the reset cycle or the following cycle.
- Synchronisers:
  - Each button and each code bit passes through 2 flops before use.
  - Code bits are synchronised bitwise; debouncing the switches is not required.
- Debounce FSM (one per button), states LOW, PEND_HIGH, HIGH, PEND_LOW:
  - LOW: sync=1 -> PEND_HIGH, counter=1.
  - PEND_HIGH: sync=0 -> LOW, counter cleared. sync=1 with counter==DEBOUNCE_CYCLES-1 -> HIGH, level=1. Otherwise counter+1.
  - HIGH / PEND_LOW: mirror of the above. Entering LOW from PEND_LOW sets level=0 and raises the release event.
  - Counter is 16-bit and saturates, never wraps.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
- Latency:
  - Release event is registered: pulse appears exactly DEBOUNCE_CYCLES+2 cycles after the raw pin falls and stays low.
  - The +2 is the synchroniser.
  - Pulse width is exactly 1 cycle.
- Code capture:
  - code_out loads the synchronised code in the same cycle its pulse is asserted.
  - code_out is held until the next emitted pulse.
  - A suppressed pulse does not update code_out.
- Holdoff:
  - An emitted pulse loads the holdoff counter with HOLDOFF_CYCLES; it decrements to 0.
  - Release events while the counter is nonzero are dropped: debounce levels still update, pulse is not emitted.
- Simultaneous releases (same cycle):
  - enter_pulse wins; set_pulse is suppressed.
  - collision=1 for that cycle; code_out is captured once.
- Press events (0->1) never produce pulses.

Test Plan:
1. Reset, then btn_enter_raw high 2000 cycles, then low, code_raw=7'h35 -> enter_pulse one cycle at fall+1002, code_out=7'h35 at that cycle, enter_level 1 then 0.
2. btn_set_raw high for 500 cycles only (< DEBOUNCE_CYCLES) -> set_level stays 0, no set_pulse, code_out unchanged.
3. Bounce: enter toggles every 10 cycles for 300 cycles, settles high 1500, bounces on release, settles low -> exactly one enter_pulse, 1000 cycles after last bounce+2.
4. Both buttons held, then released on the same clk edge, code_raw=7'h12 -> enter_pulse=1, set_pulse=0, collision=1, code_out=7'h12.
5. Set release accepted, enter release accepted 50 cycles later (HOLDOFF_CYCLES=100) -> set_pulse only; code_out holds value from set pulse. Repeat with 150 cycles -> both pulses.
6. rst asserted for 1 cycle at counter=800 of a pending release -> all outputs 0, no pulse; a fresh full release afterwards is accepted normally.
